// File: rtl/trace_reader_pkg.sv
// Shared types and defaults for the trace buffer readout block.
// The package name DTB_PKG is kept for compatibility with the rest of the trace buffer.
package DTB_PKG;

  localparam int TRB_WIDTH_DEF = 32;
  localparam int TRB_DEPTH_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    OUTPUT
  } reader_state_t;

endpackage

// File: rtl/trace_reader.sv
// Streams COUNT_I words from the trace memory, starting at START_ADDR_I, over a valid/ready port.
// Defining TRACE_READER_PREFETCH_EN adds a one-word prefetch register so the stream can sustain one word per cycle.
module trace_reader
  import DTB_PKG::*;
#(
  parameter int TRB_WIDTH = TRB_WIDTH_DEF,
  parameter int TRB_DEPTH = TRB_DEPTH_DEF,
  localparam int AW = $clog2(TRB_DEPTH)
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 START_I,
  input  logic [AW-1:0]        START_ADDR_I,
  input  logic [AW:0]          COUNT_I,
  input  logic                 RW_TURN_I,
  output logic                 RD_O,
  output logic [AW-1:0]        RD_PTR_O,
  input  logic [TRB_WIDTH-1:0] DMEM_I,
  output logic [TRB_WIDTH-1:0] DATA_O,
  output logic                 VALID_O,
  input  logic                 READY_I,
  output logic                 BUSY_O,
  output logic                 DONE_O
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(TRB_DEPTH);

  reader_state_t        state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [AW:0]          rem_q, rem_d;      // words still to be fetched
  logic [TRB_WIDTH-1:0] data_q, data_d;
  logic                 rd_q, rd_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fetch;
`ifdef TRACE_READER_PREFETCH_EN
  logic [TRB_WIDTH-1:0] pf_data_q, pf_data_d;
  logic                 pf_valid_q, pf_valid_d;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef TRACE_READER_PREFETCH_EN
    pf_data_d  = pf_data_q;
    pf_valid_d = pf_valid_q;
`endif
    // A word is read whenever the request is up and the memory grants the turn.
    fetch = rd_q && RW_TURN_I;
    if (fetch) begin
      ptr_d = ptr_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (START_I) begin
          ptr_d = START_ADDR_I;
          rem_d = (COUNT_I > DEPTH_CNT) ? DEPTH_CNT : COUNT_I;
          if (COUNT_I == '0) done_d  = 1'b1;
          else               state_d = FETCH;
        end
      end
      FETCH: begin
        if (fetch) begin
          data_d  = DMEM_I;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
`ifdef TRACE_READER_PREFETCH_EN
        if (READY_I) begin
          if (pf_valid_q) begin
            data_d     = pf_data_q;
            pf_valid_d = 1'b0;
          end else if (fetch) begin
            data_d = DMEM_I;
          end else if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end else if (fetch) begin
          pf_data_d  = DMEM_I;
          pf_valid_d = 1'b1;
        end
`else
        if (READY_I) begin
          if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase

`ifdef TRACE_READER_PREFETCH_EN
    rd_d = (state_d == FETCH) ||
           ((state_d == OUTPUT) && !pf_valid_d && (rem_d != '0));
`else
    rd_d = (state_d == FETCH);
`endif
    valid_d = (state_d == OUTPUT);
    busy_d  = (state_d != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments only; the data registers are reset too because DATA_O must read 0 after reset.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TRACE_READER_PREFETCH_EN
      pf_data_q  <= '0;
      pf_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef TRACE_READER_PREFETCH_EN
      pf_data_q  <= pf_data_d;
      pf_valid_q <= pf_valid_d;
`endif
    end
  end

  assign RD_O     = rd_q;
  assign RD_PTR_O = ptr_q;
  assign DATA_O   = data_q;
  assign VALID_O  = valid_q;
  assign BUSY_O   = busy_q;
  assign DONE_O   = done_q;

endmodule

// File: tb/tb_trace_reader.sv
// Self-checking bench for trace_reader: directed readouts plus randomized handshakes against a queue-based reference.
module tb_trace_reader;

  localparam int W  = 32;
  localparam int D  = 64;
  localparam int AW = 6;

  logic          CLK_I = 1'b0;
  logic          RST_I;
  logic          START_I;
  logic [AW-1:0] START_ADDR_I;
  logic [AW:0]   COUNT_I;
  logic          RW_TURN_I;
  logic          RD_O;
  logic [AW-1:0] RD_PTR_O;
  logic [W-1:0]  DMEM_I;
  logic [W-1:0]  DATA_O;
  logic          VALID_O;
  logic          READY_I;
  logic          BUSY_O;
  logic          DONE_O;

  logic [W-1:0] mem [D];
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  assign DMEM_I = mem[RD_PTR_O];

  always #5 CLK_I = ~CLK_I;

  trace_reader #(.TRB_WIDTH(W), .TRB_DEPTH(D)) dut (
    .CLK_I        (CLK_I),
    .RST_I        (RST_I),
    .START_I      (START_I),
    .START_ADDR_I (START_ADDR_I),
    .COUNT_I      (COUNT_I),
    .RW_TURN_I    (RW_TURN_I),
    .RD_O         (RD_O),
    .RD_PTR_O     (RD_PTR_O),
    .DMEM_I       (DMEM_I),
    .DATA_O       (DATA_O),
    .VALID_O      (VALID_O),
    .READY_I      (READY_I),
    .BUSY_O       (BUSY_O),
    .DONE_O       (DONE_O)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_flags"}, {RD_O, VALID_O, BUSY_O, DONE_O}, 4'b0000);
    check({tag, "_data"},  DATA_O, '0);
    check({tag, "_ptr"},   RD_PTR_O, '0);
  endtask

  // Reference: a readout of cnt words from sa delivers mem[(sa+k) mod D] for k < min(cnt, D), reading those addresses in order.
  task automatic do_readout(input string tag, input int sa, input int cnt,
                            input int rw_pct, input int rdy_pct, input int stall_at);
    logic [W-1:0] exp_data [$];
    int           exp_addr [$];
    int n, cyc, delivered, fetches, first_valid, stall_left, stall_reads;
    bit done_seen, holding, in_stall;
    logic [W-1:0] held;

    n = (cnt > D) ? D : cnt;
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back((sa + k) % D);
      exp_data.push_back(mem[(sa + k) % D]);
    end
    delivered = 0; fetches = 0; first_valid = -1; stall_left = 10; stall_reads = 0;
    done_seen = 0; holding = 0; held = '0;

    START_I = 1'b1; START_ADDR_I = AW'(sa); COUNT_I = (AW+1)'(cnt);
    RW_TURN_I = 1'b0; READY_I = 1'b0;
    step();
    START_I = 1'b0;

    cyc = 0;
    while (cyc < 2000) begin
      if (holding) begin
        check({tag, "_hold_valid"}, VALID_O, 1'b1);
        check({tag, "_hold_data"},  DATA_O, held);
      end
      if (DONE_O) begin
        done_seen = 1;
        break;
      end
      check({tag, "_busy"}, BUSY_O, 1'b1);

      RW_TURN_I = ($urandom_range(99) < rw_pct);
      READY_I   = ($urandom_range(99) < rdy_pct);
      in_stall  = 0;
      if (stall_at >= 0 && delivered == stall_at && stall_left > 0) begin
        READY_I = 1'b0;
        stall_left--;
        in_stall = 1;
      end
      // Requests while busy must be ignored.
      START_I      = ($urandom_range(3) == 0);
      START_ADDR_I = AW'($urandom);
      COUNT_I      = (AW+1)'($urandom);

      if (RD_O && RW_TURN_I) begin
        if (fetches < n) check({tag, "_addr"}, RD_PTR_O, exp_addr[fetches]);
        fetches++;
        if (in_stall) stall_reads++;
      end
      if (VALID_O && first_valid < 0) first_valid = cyc;
      if (VALID_O && READY_I) begin
        if (delivered < n) check({tag, "_word"}, DATA_O, exp_data[delivered]);
        delivered++;
      end
      holding = VALID_O && !READY_I;
      held    = DATA_O;
      step();
      cyc++;
    end
    START_I = 1'b0; READY_I = 1'b0; RW_TURN_I = 1'b0;

    check({tag, "_done_seen"}, done_seen, 1'b1);
    check({tag, "_delivered"}, delivered, n);
    check({tag, "_fetches"},   fetches, n);
    check({tag, "_idle_after"}, {BUSY_O, VALID_O, RD_O}, 3'b000);
    if (n == 0) check({tag, "_done_latency"}, cyc, 0);
    if (stall_at >= 0) check({tag, "_stall_reads_le1"}, (stall_reads <= 1), 1'b1);
    if (rw_pct == 100 && n > 0) check({tag, "_first_valid_cycle"}, first_valid, 1);
    step();
    check({tag, "_done_single_pulse"}, DONE_O, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    for (int i = 0; i < D; i++) mem[i] = W'(i);

    // Reset wins over a concurrent start request.
    RST_I = 1'b1; START_I = 1'b1; START_ADDR_I = '0; COUNT_I = 7'd5;
    RW_TURN_I = 1'b1; READY_I = 1'b1;
    step();
    step();
    check_cleared("reset");
    RST_I = 1'b0; START_I = 1'b0; RW_TURN_I = 1'b0; READY_I = 1'b0;
    step();
    check("reset_stays_idle", BUSY_O, 1'b0);

    do_readout("basic_5_3",   5,   3, 100, 100, -1);
    do_readout("wrap_62_4",   62,  4, 100, 100, -1);
    do_readout("count_zero",  9,   0, 100, 100, -1);
    do_readout("count_100",   10, 100, 100, 100, -1);
    do_readout("stall_10",    20,  8, 100, 100, 3);

    // Reset in the middle of a readout after two words have been delivered.
    START_I = 1'b1; START_ADDR_I = '0; COUNT_I = 7'd8;
    step();
    START_I = 1'b0; RW_TURN_I = 1'b1; READY_I = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && got < 2; i++) begin
      if (VALID_O) got++;
      step();
    end
    check("midrst_two_words", got, 2);
    RST_I = 1'b1; START_I = 1'b1;
    step();
    check_cleared("midrst");
    RST_I = 1'b0; START_I = 1'b0; RW_TURN_I = 1'b0; READY_I = 1'b0;
    step();
    check("midrst_idle", {BUSY_O, DONE_O}, 2'b00);
    do_readout("after_rst", 0, 8, 100, 100, -1);

    for (int i = 0; i < D; i++) mem[i] = $urandom;
    for (int t = 0; t < 6; t++) begin
      do_readout($sformatf("rnd%0d", t), $urandom_range(D - 1), $urandom_range(70),
                 40 + 10 * t, 90 - 10 * t, (t % 2 == 1) ? int'($urandom_range(4)) : -1);
    end
    do_readout("rnd_full_rate", $urandom_range(D - 1), 20, 100, 100, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/trace_reader.md
TRACE_READER -- requirements
Module: trace_reader

Interface
REQ-001 SHALL have parameter TRB_WIDTH, default 32: memory word width in bits.
REQ-002 SHALL have parameter TRB_DEPTH, default 64: memory depth in words, power of two, at least 2; AW = clog2(TRB_DEPTH).
REQ-003 SHALL have port CLK_I  in  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port RST_I  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port START_I  in  1: one-cycle readout request.
REQ-006 SHALL have port START_ADDR_I  in  AW: address of the first word to read.
REQ-007 SHALL have port COUNT_I  in  AW+1: number of words to read.
REQ-008 SHALL have port RW_TURN_I  in  1: memory access is granted in this cycle.
REQ-009 SHALL have port RD_O  out  1: memory read request.
REQ-010 SHALL have port RD_PTR_O  out  AW: memory read address.
REQ-011 SHALL have port DMEM_I  in  TRB_WIDTH: read data, valid in any cycle where RD_O=1 and RW_TURN_I=1.
REQ-012 SHALL have port DATA_O  out  TRB_WIDTH: streamed word.
REQ-013 SHALL have port VALID_O  out  1: DATA_O is valid.
REQ-014 SHALL have port READY_I  in  1: the consumer accepts DATA_O.
REQ-015 SHALL have port BUSY_O  out  1: a readout is in progress.
REQ-016 SHALL have port DONE_O  out  1: one-cycle pulse when a readout completes.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, OUTPUT.
REQ-018 IDLE + START_I: latch ptr=START_ADDR_I and remaining=min(COUNT_I,TRB_DEPTH), then:
- remaining>0 → FETCH.
- COUNT_I=0 → DONE_O=1 next cycle, stay IDLE, no read.
REQ-019 FETCH SHALL drive RD_O=1 and RD_PTR_O=ptr; on RW_TURN_I=1 it SHALL, in one edge:
- capture DMEM_I into the output register;
- set ptr=(ptr+1) mod TRB_DEPTH and remaining-=1;
- go to OUTPUT.
REQ-020 FETCH without RW_TURN_I: RD_O, RD_PTR_O and state held.
REQ-021 OUTPUT SHALL drive VALID_O=1; a transfer occurs when VALID_O=1 and READY_I=1.
REQ-022 On a transfer in OUTPUT:
- nothing left to deliver → IDLE, DONE_O=1 that cycle;
- otherwise → FETCH.
REQ-023 While VALID_O=1 and READY_I=0, DATA_O and VALID_O SHALL be held stable.
REQ-024 START_I while BUSY_O=1 SHALL be ignored.
REQ-025 ptr SHALL wrap from TRB_DEPTH-1 to 0 with no gap or stall.
REQ-026 BUSY_O SHALL be 1 exactly when state is not IDLE.
REQ-027 RD_O SHALL never be 1 in IDLE.
REQ-028 Minimum latency: first VALID_O two cycles after START_I, given RW_TURN_I=1.

Reset
REQ-029 RST_I=1 at an edge SHALL force IDLE and set RD_O, VALID_O, BUSY_O, DONE_O, DATA_O, RD_PTR_O, ptr and remaining to 0, including mid-readout.
REQ-030 Reset SHALL take priority over START_I, RW_TURN_I and READY_I in the same cycle.

Configuration
REQ-031 Macro TRACE_READER_PREFETCH_EN SHALL select the fetch mode.
REQ-032 Defined: a one-word prefetch register SHALL be added.
- In OUTPUT, RD_O=1 whenever the prefetch register is empty and words remain to fetch.
- On a transfer, prefetched data moves to DATA_O in the same edge; VALID_O stays 1 and there is no FETCH bubble.
- Sustained rate: one word per cycle when RW_TURN_I=1 and READY_I=1.
- A fetch and a transfer in the same cycle SHALL both complete.
REQ-033 Undefined: no prefetch register; behaviour per REQ-019..022 (maximum one word per two cycles).

Structure
REQ-034 The reader_state_t enum, TRB_WIDTH and TRB_DEPTH defaults SHALL live in DTB_PKG.
REQ-035 SHALL be a single module with no sub-module.

Verification
REQ-036 START_ADDR_I=5, COUNT_I=3, RW_TURN_I=1, READY_I=1, mem[i]=i → DATA_O 5,6,7, then one DONE_O pulse, then BUSY_O=0.
REQ-037 START_ADDR_I=62, COUNT_I=4 → RD_PTR_O 62,63,0,1 and data in that order.
REQ-038 COUNT_I=0 → DONE_O pulse next cycle, RD_O never asserted.
REQ-039 COUNT_I=100 (TRB_DEPTH=64) → exactly 64 words delivered.
REQ-040 READY_I=0 for 10 cycles mid-stream → DATA_O stable; with PREFETCH_EN at most 1 extra read, then resume with no loss.
REQ-041 RST_I pulsed after 2 of 8 words → all outputs 0 next cycle; new START_I then works normally.
